// File: rtl/sda_reg_bus_arbiter.sv
// Round-robin arbiter sharing the register bus (regReq/regAck) among NumReq requesters.
// Optional ISSUE timeout with error response when SDA_REG_ARB_TIMEOUT_EN is defined.
module sda_reg_bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int RegAddrWidth  = 8,
  parameter int TimeoutCycles = 255
) (
  input  logic                             clk,
  input  logic                             srst,
  input  logic [NumReq-1:0]                reqValid,
  output logic [NumReq-1:0]                reqReady,
  input  logic [NumReq-1:0]                reqWriteEn,
  input  logic [NumReq*RegAddrWidth-1:0]   reqAddr,
  input  logic [NumReq*32-1:0]             reqWData,
  input  logic [NumReq*4-1:0]              reqWStrb,
  output logic [NumReq-1:0]                respValid,
  output logic                             respErr,
  output logic [31:0]                      respRData,
  output logic                             regReq,
  input  logic                             regAck,
  output logic                             regWriteEn,
  output logic [RegAddrWidth-1:0]          regAddr,
  output logic [31:0]                      regWData,
  output logic [3:0]                       regWStrb,
  input  logic [31:0]                      regRData,
  output logic                             busIdle
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e                  state_q, state_d;
  logic [PtrW-1:0]         last_q, last_d;
  logic [PtrW-1:0]         gnt_q, gnt_d;
  logic [NumReq-1:0]       req_ready_q, req_ready_d;
  logic [NumReq-1:0]       resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    reg_req_q, reg_req_d;
  logic                    reg_we_q, reg_we_d;
  logic [RegAddrWidth-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]             reg_wdata_q, reg_wdata_d;
  logic [3:0]              reg_wstrb_q, reg_wstrb_d;
  logic                    bus_idle_q, bus_idle_d;

  logic                    pick_found;
  logic [PtrW-1:0]         pick_idx;
  logic [PtrW-1:0]         cand_idx;
  int                      cand;
  logic                    done;
  logic                    err;

`ifdef SDA_REG_ARB_TIMEOUT_EN
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  logic                    resp_err_q, resp_err_d;
`else
  logic                    unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
`endif

  // Round-robin search: first valid requester strictly after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NumReq; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      cand_idx = PtrW'(cand);
      if (!pick_found && reqValid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    resp_rdata_d = '0;
    reg_req_d    = reg_req_q;
    reg_we_d     = reg_we_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wstrb_d  = reg_wstrb_q;
    done         = 1'b0;
    err          = 1'b0;
`ifdef SDA_REG_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    resp_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          req_ready_d[pick_idx] = 1'b1;
          reg_req_d   = 1'b1;
          reg_we_d    = reqWriteEn[pick_idx];
          reg_addr_d  = reqAddr[int'(pick_idx)*RegAddrWidth +: RegAddrWidth];
          reg_wdata_d = reqWData[int'(pick_idx)*32 +: 32];
          reg_wstrb_d = reqWStrb[int'(pick_idx)*4 +: 4];
          last_d      = pick_idx;
          gnt_d       = pick_idx;
          state_d     = ISSUE;
`ifdef SDA_REG_ARB_TIMEOUT_EN
          tmo_cnt_d   = '0;
`endif
        end
      end
      ISSUE: begin
        if (regAck) begin
          done         = 1'b1;
          resp_rdata_d = reg_we_q ? 32'h0 : regRData;
`ifdef SDA_REG_ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == 16'(TimeoutCycles - 1)) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
        end
        if (done) begin
          resp_valid_d[gnt_q] = 1'b1;
          reg_req_d   = 1'b0;
          reg_we_d    = 1'b0;
          reg_wdata_d = '0;
          reg_wstrb_d = '0;
          state_d     = RESP;
`ifdef SDA_REG_ARB_TIMEOUT_EN
          resp_err_d  = err;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    bus_idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= IDLE;
      last_q       <= PtrW'(NumReq - 1);
      gnt_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      reg_req_q    <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_wstrb_q  <= '0;
      bus_idle_q   <= 1'b1;
`ifdef SDA_REG_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      reg_req_q    <= reg_req_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wstrb_q  <= reg_wstrb_d;
      bus_idle_q   <= bus_idle_d;
`ifdef SDA_REG_ARB_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      resp_err_q   <= resp_err_d;
`endif
    end
  end

  assign reqReady   = req_ready_q;
  assign respValid  = resp_valid_q;
  assign respRData  = resp_rdata_q;
`ifdef SDA_REG_ARB_TIMEOUT_EN
  assign respErr    = resp_err_q;
`else
  assign respErr    = 1'b0;
`endif
  assign regReq     = reg_req_q;
  assign regWriteEn = reg_we_q;
  assign regAddr    = reg_addr_q;
  assign regWData   = reg_wdata_q;
  assign regWStrb   = reg_wstrb_q;
  assign busIdle    = bus_idle_q;

endmodule

// File: tb/tb_sda_reg_bus_arbiter.sv
// Directed bench for sda_reg_bus_arbiter: single read, bus write, round-robin writes,
// stalled ISSUE (timeout or hang), reset mid-transaction and stray ack.
module tb_sda_reg_bus_arbiter;
  localparam int NR = 2;
  localparam int AW = 8;

  logic              clk = 1'b0;
  logic              srst;
  logic [NR-1:0]     reqValid, reqReady, reqWriteEn, respValid;
  logic [NR*AW-1:0]  reqAddr;
  logic [NR*32-1:0]  reqWData;
  logic [NR*4-1:0]   reqWStrb;
  logic              respErr;
  logic [31:0]       respRData;
  logic              regReq, regAck, regWriteEn;
  logic [AW-1:0]     regAddr;
  logic [31:0]       regWData, regRData;
  logic [3:0]        regWStrb;
  logic              busIdle;

  logic slv_en, slv_ack, stray_ack, mon_en;
  int   slv_lat, slv_cnt, low_cnt, min_gap, n_rise;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;
  assign regAck = slv_ack | stray_ack;

  sda_reg_bus_arbiter #(.NumReq(NR), .RegAddrWidth(AW), .TimeoutCycles(16)) dut (
    .clk(clk), .srst(srst), .reqValid(reqValid), .reqReady(reqReady),
    .reqWriteEn(reqWriteEn), .reqAddr(reqAddr), .reqWData(reqWData), .reqWStrb(reqWStrb),
    .respValid(respValid), .respErr(respErr), .respRData(respRData),
    .regReq(regReq), .regAck(regAck), .regWriteEn(regWriteEn), .regAddr(regAddr),
    .regWData(regWData), .regWStrb(regWStrb), .regRData(regRData), .busIdle(busIdle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel=0 waits for a reqReady pulse, sel=1 for a respValid pulse; bounded.
  task automatic wait_ev(input bit sel, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if ((sel ? |respValid : |reqReady)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Slave: acks slv_lat cycles after it first sees regReq high.
  initial begin
    slv_ack = 1'b0;
    slv_cnt = 0;
    forever begin
      tick();
      if (slv_en && regReq && !slv_ack) begin
        slv_cnt++;
        slv_ack = (slv_cnt == slv_lat + 1);
      end else begin
        slv_cnt = 0;
        slv_ack = 1'b0;
      end
    end
  end

  // Tracks the shortest regReq-low gap before each rise while mon_en is set.
  initial begin
    low_cnt = 0;
    min_gap = 1000;
    n_rise  = 0;
    forever begin
      tick();
      if (!regReq) low_cnt++;
      else begin
        if (low_cnt > 0 && mon_en) begin
          n_rise++;
          if (low_cnt < min_gap) min_gap = low_cnt;
        end
        low_cnt = 0;
      end
    end
  end

  initial begin
    bit ok;
    int ex, seen, drops;
    int wcnt[2];
    srst = 1'b1; reqValid = '0; reqWriteEn = '0; reqAddr = '0; reqWData = '0; reqWStrb = '0;
    regRData = 32'hDEAD_BEEF; slv_en = 1'b0; slv_lat = 2; stray_ack = 1'b0; mon_en = 1'b0;
    tick(); tick();
    chk("rst_idle", 32'(busIdle), 32'd1);
    chk("rst_req", 32'(regReq), 32'd0);
    chk("rst_ready", 32'(reqReady), 32'd0);
    chk("rst_resp", 32'(respValid), 32'd0);
    srst = 1'b0;
    tick();

    // Requester 0 reads 0x00, ack 2 cycles after regReq rises.
    slv_en = 1'b1; slv_lat = 2; regRData = 32'h0000_0004;
    reqValid = 2'b01; reqWriteEn = 2'b00; reqAddr = 16'h0000;
    tick();
    chk("rd_ready", 32'(reqReady), 32'd1);
    chk("rd_req0", 32'(regReq), 32'd1);
    chk("rd_idle", 32'(busIdle), 32'd0);
    reqValid = '0;
    tick(); chk("rd_req1", 32'(regReq), 32'd1);
    tick(); chk("rd_req2", 32'(regReq), 32'd1);
    tick();
    chk("rd_req3", 32'(regReq), 32'd0);
    chk("rd_resp", 32'(respValid), 32'd1);
    chk("rd_data", respRData, 32'h4);
    chk("rd_err", 32'(respErr), 32'd0);
    tick();
    chk("rd_resp_clr", 32'(respValid), 32'd0);
    chk("rd_data_clr", respRData, 32'd0);
    chk("rd_idle2", 32'(busIdle), 32'd1);

    // Requester 1 writes 0x08 <= 0x3, strb 0x1; slave returns nonzero data.
    regRData = 32'hDEAD_BEEF;
    reqValid = 2'b10; reqWriteEn = 2'b10; reqAddr = 16'h0800;
    reqWData = {32'h0000_0003, 32'h0}; reqWStrb = 8'h10;
    tick();
    chk("wr_ready", 32'(reqReady), 32'd2);
    reqValid = '0;
    for (int c = 0; c < 3; c++) begin
      chk("wr_req", 32'(regReq), 32'd1);
      chk("wr_we", 32'(regWriteEn), 32'd1);
      chk("wr_addr", 32'(regAddr), 32'h08);
      chk("wr_wdata", regWData, 32'h3);
      chk("wr_wstrb", 32'(regWStrb), 32'h1);
      tick();
    end
    chk("wr_resp", 32'(respValid), 32'd2);
    chk("wr_rdata", respRData, 32'd0);
    chk("wr_we_off", 32'(regWriteEn), 32'd0);
    chk("wr_wdata_off", regWData, 32'd0);
    chk("wr_wstrb_off", 32'(regWStrb), 32'd0);
    chk("wr_addr_hold", 32'(regAddr), 32'h08);

    // Both requesters continuously valid, 6 writes each.
    slv_lat = 1; mon_en = 1'b1; wcnt[0] = 0; wcnt[1] = 0;
    reqWriteEn = 2'b11; reqAddr = 16'h1000; reqWData = {32'h1111_1111, 32'h2222_2222};
    reqWStrb = 8'hFF; reqValid = 2'b11;
    for (int t = 0; t < 12; t++) begin
      ex = t % 2;
      wait_ev(1'b0, "rr_ready", ok);
      if (!ok) break;
      chk("rr_grant", 32'(reqReady), 32'(1 << ex));
      chk("rr_addr", 32'(regAddr), 32'(ex * 16 + wcnt[ex]));
      wcnt[ex]++;
      reqAddr[ex*8 +: 8] = 8'(ex * 16 + wcnt[ex]);
      if (wcnt[ex] == 6) reqValid[ex] = 1'b0;
      wait_ev(1'b1, "rr_resp", ok);
      if (!ok) break;
      chk("rr_resp", 32'(respValid), 32'(1 << ex));
      chk("rr_rdata", respRData, 32'd0);
    end
    tick();
    mon_en = 1'b0;
    chk("rr_gap", 32'(min_gap >= 2), 32'd1);
    chk("rr_rises", 32'(n_rise), 32'd12);

    // Requester 0 reads 0xF0, slave never acks.
    slv_en = 1'b0; reqWriteEn = '0; reqAddr = 16'h00F0; reqValid = 2'b01;
    tick();
    chk("stall_ready", 32'(reqReady), 32'd1);
    reqValid = '0;
    seen = 0; drops = 0;
`ifdef SDA_REG_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      if (respValid != '0) seen++;
      if (!regReq) drops++;
    end
    chk("to_early_resp", 32'(seen), 32'd0);
    chk("to_early_drop", 32'(drops), 32'd0);
    tick();
    chk("to_resp", 32'(respValid), 32'd1);
    chk("to_err", 32'(respErr), 32'd1);
    chk("to_rdata", respRData, 32'd0);
    chk("to_req", 32'(regReq), 32'd0);
    tick();
    reqValid = 2'b01;
    wait_ev(1'b0, "to_ready2", ok);
    reqValid = '0;
    tick();
`else
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (respValid != '0) seen++;
      if (!regReq) drops++;
    end
    chk("hang_resp", 32'(seen), 32'd0);
    chk("hang_drop", 32'(drops), 32'd0);
`endif

    // Reset while requester 0 is in ISSUE.
    srst = 1'b1;
    tick();
    chk("mid_rst_req", 32'(regReq), 32'd0);
    chk("mid_rst_resp", 32'(respValid), 32'd0);
    chk("mid_rst_idle", 32'(busIdle), 32'd1);
    srst = 1'b0;
    slv_en = 1'b1; slv_lat = 1; regRData = 32'h0000_0055;
    reqAddr = 16'h3020; reqValid = 2'b11;
    tick();
    chk("post_rst_grant", 32'(reqReady), 32'd1);
    reqValid = 2'b10;
    wait_ev(1'b1, "post_rst_resp0", ok);
    chk("post_rst_resp0", 32'(respValid), 32'd1);
    chk("post_rst_data0", respRData, 32'h55);
    wait_ev(1'b0, "post_rst_ready1", ok);
    chk("post_rst_grant1", 32'(reqReady), 32'd2);
    reqValid = '0;
    wait_ev(1'b1, "post_rst_resp1", ok);
    chk("post_rst_resp1", 32'(respValid), 32'd2);
    tick(); tick();

    // Stray ack while idle.
    slv_en = 1'b0; stray_ack = 1'b1;
    tick();
    chk("stray_resp", 32'(respValid), 32'd0);
    chk("stray_idle", 32'(busIdle), 32'd1);
    stray_ack = 1'b0;
    tick();
    chk("stray_resp2", 32'(respValid), 32'd0);
    chk("stray_idle2", 32'(busIdle), 32'd1);
    chk("stray_req", 32'(regReq), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/sda_reg_bus_arbiter.md
Name: sda_reg_bus_arbiter

Overview:
Shares the simple register interface (regReq/regAck/regWriteEn/regAddr/regWData/regWStrb/regRData) between NumReq requesters, such as the host AXI-lite adapter and an on-chip debug master.
- Grants one requester at a time, round-robin.
- Drives a single register transaction onto the ORed slave bus and returns the ack/read data to the granted requester.
- Guarantees regReq is low between transactions, because slaves detect requests on the rising edge.
- Sits between the requester adapters and the ORed set of register blocks, including the kernel control registers.

Parameters:
NumReq, 2, number of requesters (2..8).
RegAddrWidth, 8, register address width.
TimeoutCycles, 255, cycles regReq may stay high without regAck before an error response (optional feature only; 1..65535).

Ports:
clk  input  1  clock
srst  input  1  synchronous active-high reset
reqValid  input  NumReq  per-requester request valid; held until reqReady
reqReady  output  NumReq  one-hot, single-cycle accept pulse
reqWriteEn  input  NumReq  per-requester write enable
reqAddr  input  NumReq*RegAddrWidth  packed addresses; requester i at [i*RegAddrWidth +: RegAddrWidth]
reqWData  input  NumReq*32  packed write data
reqWStrb  input  NumReq*4  packed byte strobes
respValid  output  NumReq  one-hot, single-cycle response pulse
respErr  output  1  response error flag, qualified by respValid
respRData  output  32  response read data, qualified by respValid
regReq  output  1  bus request, level, held until regAck
regAck  input  1  ORed slave ack pulse
regWriteEn  output  1  bus write enable
regAddr  output  RegAddrWidth  bus address
regWData  output  32  bus write data
regWStrb  output  4  bus byte strobes
regRData  input  32  ORed slave read data
busIdle  output  1  high in IDLE state

Behaviour:
- Clock and reset: one clock, clk. Reset srst is synchronous and active-high.
- Outputs after reset: all low except busIdle=1. State=IDLE. Round-robin pointer last=NumReq-1, so requester 0 wins first.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - regReq=0.
  - If any reqValid bit is set, grant g = first set bit searching upward from last+1, wrapping modulo NumReq.
  - Registered outputs: reqReady[g]=1 for exactly one cycle; g's writeEn/addr/wdata/wstrb latched into the bus registers; last<=g; next state ISSUE.
- ISSUE:
  - regReq=1. Bus fields stay stable for the whole state.
  - On regAck=1: capture regRData (reads) or 0 (writes), err=0, go to RESP.
- RESP:
  - regReq=0.
  - respValid[g]=1 for one cycle, with respRData/respErr valid in the same cycle.
  - Next state IDLE.
- Request spacing: regReq is low for at least 2 cycles (RESP, IDLE) between transactions. Minimum per-requester turnaround = slave ack latency + 3 cycles.
- Ownership: a requester may have only one transaction outstanding. reqValid may drop only after its reqReady pulse.
- Unused bus fields: regWData, regWStrb and regWriteEn are driven to 0 when not in ISSUE. regAddr holds its last value.
- Response bus: respRData and respErr are 0 whenever respValid is all-zero.
- No response backpressure: a requester must sample the respValid pulse.
- Stray regAck in IDLE or RESP is ignored and produces no response.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NumReq-1,0. No requester waits more than NumReq-1 transactions.
- srst asserted mid-transaction: regReq drops in the next cycle, the pending response is discarded (no respValid), and the pointer resets.

Optional Feature:
Macro SDA_REG_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to ISSUE and increments every ISSUE cycle.
  - When the counter reaches TimeoutCycles without regAck, go to RESP with respErr=1 and respRData=0.
  - regAck in the same cycle as expiry wins: respErr=0.
- Undefined:
  - No counter. ISSUE waits indefinitely.
  - respErr is tied 0.
  - TimeoutCycles is unused.

Test Plan:
- Reset, then requester 0 reads addr 0x00; slave acks 2 cycles after regReq rises with data 0x0000_0004 -> reqReady[0] pulse, regReq high 3 cycles, respValid=2'b01, respRData=0x4, respErr=0.
- Both requesters valid continuously, 6 writes each -> grant order 0,1,0,1,...; regReq low at least 2 cycles between each of the 12 transactions; writes return respRData=0.
- Requester 1 writes addr 0x08 data 0x3 strb 0x1 -> bus shows regWriteEn=1, regAddr=0x08, regWData=0x3, regWStrb=0x1 stable while regReq high; respValid=2'b10.
- With SDA_REG_ARB_TIMEOUT_EN and TimeoutCycles=16, read addr 0xF0 with no slave ack -> respValid after 16 ISSUE cycles, respErr=1, respRData=0; without the macro, regReq stays high and there is no response after 1000 cycles.
- srst pulsed for 1 cycle while in ISSUE -> regReq low next cycle, no respValid, next grant goes to requester 0 even though requester 0 was granted last.
- Stray regAck injected while IDLE with no requests -> no respValid, busIdle stays 1.
